// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: time-multiplexes NUM_DIGITS common-anode digits
// through one shared hex decoder, with a dark interval at the start of every slot.
// New display words arrive on a valid/ready port and are committed only at frame
// boundaries (or immediately while idle), so a frame never mixes old and new values.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero suppression.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned DIV_MAX    = 49999,
  parameter int unsigned BLANK_CYC  = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              dig_val_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] CntMax   = DIV_W'(DIV_MAX);
  localparam logic [DIV_W-1:0] CntBlank = DIV_W'(BLANK_CYC);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [0:0] {StIdle, StScan} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic                    ready_q, ready_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              dig_q, dig_d;
  logic                    frame_q, frame_d;

  logic                    slot_end;
  logic                    boundary;
  logic [NUM_DIGITS-1:0]   digit_on;

  // Last cycle of a slot, and last cycle of a frame that keeps scanning.
  assign slot_end = (cnt_q == CntMax);
  assign boundary = (state_q == StScan) && enable && slot_end && (idx_q == IdxLast);

`ifdef SEG_LZ_BLANK_EN
  logic lz_seen;

  // A digit may light only if it or some more significant digit is nonzero; digit 0 always may.
  always_comb begin
    lz_seen  = 1'b0;
    digit_on = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_seen     = lz_seen | (disp_q[4*i +: 4] != 4'h0);
      digit_on[i] = lz_seen | (i == 0);
    end
  end
`else
  assign digit_on = '1;
`endif

  // Next-state: scan sequencing, registered output values and the load/commit handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    an_d    = '1;
    dig_d   = 4'h0;
    frame_d = boundary;

    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        cnt_d = '0;
        if (enable) state_d = StScan;
      end
      StScan: begin
        if (!enable) begin
          state_d = StIdle;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          dig_d = disp_q[{idx_q, 2'b00} +: 4];
          if ((cnt_q > CntBlank) && digit_on[idx_q]) an_d[idx_q] = 1'b0;
          if (slot_end) begin
            cnt_d = '0;
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A word captured on a boundary edge has ready_q=1 there, so it waits for the next boundary.
    if (load_valid && ready_q) begin
      pend_d  = load_data;
      ready_d = 1'b0;
    end else if (!ready_q && ((state_q == StIdle) || boundary)) begin
      disp_d  = pend_q;
      ready_d = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
      an_q    <= '1;
      dig_q   <= 4'h0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      an_q    <= an_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end

  assign load_ready = ready_q;
  assign an_o       = an_q;
  assign dig_val_o  = dig_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: 4 digits, 8-cycle slots (2 dark), 32-cycle frames.
// A frame-position model predicts every registered output; directed pins anchor it.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * SLOT;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  dig_val_o;
  logic [3:0]  an_o;
  logic        frame_o;

  seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .DIV_W     (16),
    .DIV_MAX   (7),
    .BLANK_CYC (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .dig_val_o (dig_val_o),
    .an_o      (an_o),
    .frame_o   (frame_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  int frames   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: position within the frame plus committed/pending words.
  bit          m_active = 1'b0;
  int          m_pos    = 0;
  logic [3:0]  m_disp[ND];
  logic [15:0] m_pend   = 16'h0;
  bit          m_ready  = 1'b1;
  logic [3:0]  e_an     = 4'hF;
  logic [3:0]  e_dig    = 4'h0;
  logic        e_frame  = 1'b0;
  int          m_slot;
  int          m_cyc;

  function automatic bit lit_allowed(input int d);
`ifdef SEG_LZ_BLANK_EN
    if (d == 0) return 1'b1;
    for (int j = d; j < ND; j++) if (m_disp[j] != 4'h0) return 1'b1;
    return 1'b0;
`else
    return (d >= 0);
`endif
  endfunction

  initial begin
    for (int k = 0; k < ND; k++) m_disp[k] = 4'h0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0;
        m_pos    = 0;
        m_pend   = 16'h0;
        m_ready  = 1'b1;
        for (int k = 0; k < ND; k++) m_disp[k] = 4'h0;
        e_an    = 4'hF;
        e_dig   = 4'h0;
        e_frame = 1'b0;
      end else begin
        m_slot = m_pos / SLOT;
        m_cyc  = m_pos % SLOT;
        if (m_active && enable) begin
          e_dig   = m_disp[m_slot];
          e_an    = (m_cyc >= BLANK && lit_allowed(m_slot)) ? ~(4'b0001 << m_slot) : 4'hF;
          e_frame = (m_pos == FRAME - 1);
        end else begin
          e_dig   = 4'h0;
          e_an    = 4'hF;
          e_frame = 1'b0;
        end
        if (load_valid && m_ready) begin
          m_pend  = load_data;
          m_ready = 1'b0;
        end else if (!m_ready && (!m_active || (enable && m_pos == FRAME - 1))) begin
          for (int k = 0; k < ND; k++) m_disp[k] = m_pend[4*k +: 4];
          m_ready = 1'b1;
        end
        if (m_active && enable) begin
          m_pos = (m_pos + 1) % FRAME;
        end else begin
          m_pos    = 0;
          m_active = enable;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (frame_o === 1'b1) frames++;
      if (chk_en) begin
        check("an_o", an_o, e_an);
        check("dig_val_o", dig_val_o, e_dig);
        check("frame_o", frame_o, e_frame);
        check("load_ready", load_ready, m_ready);
      end
    end
  end

  // Advance at least one negedge, then until the model is about to process frame position t.
  task automatic wait_pos(input int t);
    int n;
    n = 0;
    @(negedge clk);
    while (!(m_active && m_pos == t) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL wait_pos: actual=timeout expected=position %0d", t);
    end
  endtask

  task automatic load_at(input int p, input logic [15:0] w);
    wait_pos(p);
    load_valid = 1'b1;
    load_data  = w;
    wait_pos((p + 1) % FRAME);
    load_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_n;
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // 1: idle and dark with enable low.
    frames = 0;
    repeat (20) @(negedge clk);
    check("t1_an", an_o, 4'hF);
    check("t1_dig", dig_val_o, 4'h0);
    check("t1_ready", load_ready, 1'b1);
    check("t1_frames", frames, 0);

    // 2: load while idle (commits next edge), then scan one full frame.
    load_valid = 1'b1;
    load_data  = 16'h1234;
    @(negedge clk);
    load_valid = 1'b0;
    check("t2_ready_low", load_ready, 1'b0);
    @(negedge clk);
    check("t2_ready_back", load_ready, 1'b1);
    enable = 1'b1;
    @(posedge clk);
    for (int p = 0; p < FRAME; p++) begin
      @(posedge clk);
      #1;
      case (p)
        0:  begin check("t2_p0_an", an_o, 4'hF); check("t2_p0_dig", dig_val_o, 4'h4); end
        2:  check("t2_p2_an", an_o, 4'hE);
        10: begin check("t2_p10_an", an_o, 4'hD); check("t2_p10_dig", dig_val_o, 4'h3); end
        19: begin check("t2_p19_an", an_o, 4'hB); check("t2_p19_dig", dig_val_o, 4'h2); end
        26: begin check("t2_p26_an", an_o, 4'h7); check("t2_p26_dig", dig_val_o, 4'h1); end
        30: check("t2_p30_frame", frame_o, 1'b0);
        31: check("t2_p31_frame", frame_o, 1'b1);
        default: ;
      endcase
    end

    // 3: load at slot 1 cycle 3; commit waits for the frame boundary.
    load_at(11, 16'hABCD);
    check("t3_ready_low", load_ready, 1'b0);
    wait_pos(20);
    check("t3_ready_hold", load_ready, 1'b0);
    check("t3_old_dig", dig_val_o, 4'h2);
    wait_pos(0);
    check("t3_last_old", dig_val_o, 4'h1);
    check("t3_frame", frame_o, 1'b1);
    check("t3_ready_ret", load_ready, 1'b1);
    wait_pos(1);
    check("t3_new_dig", dig_val_o, 4'hD);

    // 4: valid held through ready=0 with changing data: only the first word lands.
    wait_pos(5);
    load_valid = 1'b1;
    load_data  = 16'h5678;
    hold_n     = 0;
    do begin
      @(negedge clk);
      hold_n++;
      if (!load_ready) load_data = 16'($urandom);
    end while (!load_ready && hold_n < 100);
    load_valid = 1'b0;
    check("t4_hold_done", load_ready, 1'b1);
    wait_pos(1);
    check("t4_first_word", dig_val_o, 4'h8);
    // Transfer on the boundary edge commits one frame later.
    wait_pos(31);
    load_valid = 1'b1;
    load_data  = 16'h9ABC;
    wait_pos(0);
    load_valid = 1'b0;
    check("t4_bnd_ready", load_ready, 1'b0);
    wait_pos(1);
    check("t4_bnd_not_yet", dig_val_o, 4'h8);
    wait_pos(0);
    check("t4_bnd_ready_ret", load_ready, 1'b1);
    wait_pos(1);
    check("t4_bnd_commit", dig_val_o, 4'hC);

    // 5: drop enable mid-slot 2, then restart from digit 0.
    wait_pos(20);
    enable = 1'b0;
    @(negedge clk);
    check("t5_dark", an_o, 4'hF);
    check("t5_dig", dig_val_o, 4'h0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    wait_pos(1);
    check("t5_restart_an", an_o, 4'hF);
    check("t5_restart_dig", dig_val_o, 4'hC);
    wait_pos(3);
    check("t5_restart_drive", an_o, 4'hE);

    // 6: leading-zero behaviour (or plain drive when the feature is off).
    load_at(3, 16'h0050);
    wait_pos(0);
    wait_pos(5);
    check("t6_d0_an", an_o, 4'hE);
    check("t6_d0_dig", dig_val_o, 4'h0);
    wait_pos(13);
    check("t6_d1_an", an_o, 4'hD);
    check("t6_d1_dig", dig_val_o, 4'h5);
    wait_pos(21);
`ifdef SEG_LZ_BLANK_EN
    check("t6_d2_an", an_o, 4'hF);
`else
    check("t6_d2_an", an_o, 4'hB);
`endif
    wait_pos(29);
`ifdef SEG_LZ_BLANK_EN
    check("t6_d3_an", an_o, 4'hF);
`else
    check("t6_d3_an", an_o, 4'h7);
`endif
    load_at(29, 16'h0000);
    wait_pos(5);
    check("t6_zero_d0_an", an_o, 4'hE);
    check("t6_zero_d0_dig", dig_val_o, 4'h0);
    wait_pos(13);
`ifdef SEG_LZ_BLANK_EN
    check("t6_zero_d1_an", an_o, 4'hF);
`else
    check("t6_zero_d1_an", an_o, 4'hD);
`endif

    // Random traffic with one asynchronous reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_an", an_o, 4'hF);
        check("rst_ready", load_ready, 1'b1);
        check("rst_frame", frame_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if (!(load_valid && !load_ready)) begin
        load_valid = ($urandom_range(0, 7) == 0);
        load_data  = 16'($urandom);
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
